// File: rtl/shared_bus_ctrl.sv
// Shared memory port controller fed by the cluster round-robin arbiter.
// Define BUS_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYC cycles.
module shared_bus_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          gnt_arb,
    input  logic [2:0]          core_req,
    input  logic [2:0]          core_we,
    input  logic [3*ADDR_W-1:0] core_addr,
    input  logic [3*DATA_W-1:0] core_wdata,
    output logic [2:0]          core_done,
    output logic [2:0]          core_err,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        owner;
    logic [2:0]        acc;
    logic              accept;
    logic              tmo;
    logic [1:0]        sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign acc = gnt_arb & core_req;

    // Lowest set index wins when the grant is not one-hot.
    always_comb begin
        sel       = 2'd0;
        sel_we    = core_we[0];
        sel_addr  = core_addr[0 +: ADDR_W];
        sel_wdata = core_wdata[0 +: DATA_W];
        if (acc[0]) begin
            sel = 2'd0;
        end else if (acc[1]) begin
            sel       = 2'd1;
            sel_we    = core_we[1];
            sel_addr  = core_addr[ADDR_W +: ADDR_W];
            sel_wdata = core_wdata[DATA_W +: DATA_W];
        end else if (acc[2]) begin
            sel       = 2'd2;
            sel_we    = core_we[2];
            sel_addr  = core_addr[2*ADDR_W +: ADDR_W];
            sel_wdata = core_wdata[2*DATA_W +: DATA_W];
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             limit;

    assign limit = (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic limit;

    assign limit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            IDLE: begin
                if (|acc) begin
                    accept    = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                // An ack on the limit edge completes normally.
                if (mem_ack) begin
                    state_nxt = DONE;
                end else if (limit) begin
                    tmo       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner      <= 2'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt        <= '0;
            err        <= 1'b0;
`endif
        end else begin
            if (accept) begin
                owner     <= sel;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (state == BUS && mem_ack) begin
                core_rdata <= mem_rdata;
            end else if (tmo) begin
                core_rdata <= '0;
            end
`ifdef BUS_TIMEOUT_EN
            if (accept) begin
                cnt <= '0;
                err <= 1'b0;
            end else if (tmo) begin
                err <= 1'b1;
            end else if (state == BUS && !mem_ack) begin
                cnt <= cnt + 1'b1;
            end
`endif
        end
    end

    assign busy      = (state != IDLE);
    assign mem_req   = (state == BUS);
    assign core_done = (state == DONE) ? 3'(3'b001 << owner) : 3'b000;

`ifdef BUS_TIMEOUT_EN
    assign core_err = (state == DONE && err) ? core_done : 3'b000;
`else
    assign core_err = 3'b000;
`endif

endmodule

// File: tb/tb_shared_bus_ctrl.sv
// Directed bench for shared_bus_ctrl; inputs driven and outputs sampled on negedge.
// Timeout scenarios run only when BUS_TIMEOUT_EN is defined.
module tb_shared_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  gnt_arb;
    logic [2:0]  core_req;
    logic [2:0]  core_we;
    logic [47:0] core_addr;
    logic [95:0] core_wdata;
    logic [2:0]  core_done;
    logic [2:0]  core_err;
    logic [31:0] core_rdata;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    shared_bus_ctrl #(
        .ADDR_W(16),
        .DATA_W(32),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gnt_arb(gnt_arb),
        .core_req(core_req),
        .core_we(core_we),
        .core_addr(core_addr),
        .core_wdata(core_wdata),
        .core_done(core_done),
        .core_err(core_err),
        .core_rdata(core_rdata),
        .busy(busy),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        gnt_arb    = 3'b000;
        core_req   = 3'b000;
        core_we    = 3'b000;
        core_addr  = '0;
        core_wdata = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        step();
        step();
        checks++;
        if ({core_done, core_err, busy, mem_req, mem_we} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 0",
                     {core_done, core_err, busy, mem_req, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, core_rdata} !== 80'b0) begin
            errors++;
            $display("FAIL reset_data: got %h exp 0",
                     {mem_addr, mem_wdata, core_rdata});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        gnt_arb          = 3'b010;
        core_req         = 3'b010;
        core_we          = 3'b000;
        core_addr[31:16] = 16'h0040;
        step();
        checks++;
        if ({mem_req, mem_we, busy, mem_addr} !== {3'b101, 16'h0040}) begin
            errors++;
            $display("FAIL read_bus: got req=%b we=%b busy=%b addr=%h exp 1 0 1 0040",
                     mem_req, mem_we, busy, mem_addr);
        end
        gnt_arb   = 3'b000;
        core_req  = 3'b000;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE0001;
        step();
        checks++;
        if (core_done !== 3'b010 || core_err !== 3'b000 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL read_done: got done=%b err=%b req=%b exp 010 000 0",
                     core_done, core_err, mem_req);
        end
        checks++;
        if (core_rdata !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL read_data: got %h exp cafe0001", core_rdata);
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        step();
        checks++;
        if (core_done !== 3'b000 || busy !== 1'b0 || core_rdata !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL read_after: got done=%b busy=%b rdata=%h exp 000 0 cafe0001",
                     core_done, busy, core_rdata);
        end
    endtask

    task automatic test_zero_wait_write();
        mem_ack           = 1'b1;
        mem_rdata         = 32'h0BAD0BAD;
        gnt_arb           = 3'b100;
        core_req          = 3'b100;
        core_we           = 3'b100;
        core_addr[47:32]  = 16'h0100;
        core_wdata[95:64] = 32'h12345678;
        step();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0100, 32'h12345678}) begin
            errors++;
            $display("FAIL write_bus: got req=%b we=%b addr=%h wdata=%h",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        gnt_arb  = 3'b000;
        core_req = 3'b000;
        core_we  = 3'b000;
        step();
        checks++;
        if (core_done !== 3'b100 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL write_done: got done=%b req=%b exp 100 0", core_done, mem_req);
        end
        mem_ack = 1'b0;
        step();
        checks++;
        if (core_done !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_after: got done=%b busy=%b exp 000 0", core_done, busy);
        end
    endtask

    task automatic test_grant_while_busy();
        core_addr[15:0]  = 16'h0010;
        core_addr[31:16] = 16'h0020;
        core_addr[47:32] = 16'h0030;
        gnt_arb  = 3'b001;
        core_req = 3'b111;
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || core_done !== 3'b000) begin
                errors++;
                $display("FAIL busy_hold[%0d]: got req=%b addr=%h done=%b exp 1 0010 000",
                         i, mem_req, mem_addr, core_done);
            end
            gnt_arb = (i % 2 == 0) ? 3'b010 : 3'b100;
            if (i == 9) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h00000A0A;
            end
            step();
        end
        checks++;
        if (core_done !== 3'b001 || mem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL busy_done: got done=%b addr=%h exp 001 0010", core_done, mem_addr);
        end
        mem_ack  = 1'b0;
        core_req = 3'b110;
        gnt_arb  = 3'b010;
        step();
        checks++;
        if (busy !== 1'b0 || core_done !== 3'b000) begin
            errors++;
            $display("FAIL busy_idle: got busy=%b done=%b exp 0 000", busy, core_done);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0020) begin
            errors++;
            $display("FAIL busy_next: got req=%b addr=%h exp 1 0020", mem_req, mem_addr);
        end
        gnt_arb  = 3'b000;
        core_req = 3'b000;
        mem_ack  = 1'b1;
        step();
        checks++;
        if (core_done !== 3'b010) begin
            errors++;
            $display("FAIL busy_next_done: got %b exp 010", core_done);
        end
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_grant_no_req();
        gnt_arb  = 3'b001;
        core_req = 3'b000;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL no_req: got busy=%b req=%b exp 0 0", busy, mem_req);
        end
        core_addr[31:16] = 16'h0111;
        core_addr[47:32] = 16'h0222;
        gnt_arb  = 3'b110;
        core_req = 3'b110;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0111) begin
            errors++;
            $display("FAIL multi_gnt: got req=%b addr=%h exp 1 0111", mem_req, mem_addr);
        end
        gnt_arb   = 3'b000;
        core_req  = 3'b000;
        mem_ack   = 1'b1;
        mem_rdata = 32'h11112222;
        step();
        checks++;
        if (core_done !== 3'b010 || core_rdata !== 32'h11112222) begin
            errors++;
            $display("FAIL multi_done: got done=%b rdata=%h exp 010 11112222",
                     core_done, core_rdata);
        end
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_bus();
        core_addr[15:0] = 16'h0ABC;
        gnt_arb  = 3'b001;
        core_req = 3'b001;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0ABC) begin
            errors++;
            $display("FAIL rst_mid_pre: got req=%b addr=%h exp 1 0abc", mem_req, mem_addr);
        end
        gnt_arb  = 3'b000;
        core_req = 3'b000;
        rst      = 1'b0;
        step();
        checks++;
        if ({core_done, core_err, busy, mem_req, mem_we, mem_addr, mem_wdata, core_rdata}
            !== 89'b0) begin
            errors++;
            $display("FAIL rst_mid: got done=%b busy=%b req=%b addr=%h rdata=%h exp all 0",
                     core_done, busy, mem_req, mem_addr, core_rdata);
        end
        rst     = 1'b1;
        mem_ack = 1'b1;
        step();
        checks++;
        if (core_done !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: got done=%b busy=%b exp 000 0", core_done, busy);
        end
        mem_ack = 1'b0;
        step();
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        gnt_arb  = 3'b001;
        core_req = 3'b001;
        step();
        gnt_arb  = 3'b000;
        core_req = 3'b000;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (mem_req !== 1'b1 || core_done !== 3'b000) begin
                errors++;
                $display("FAIL tmo_ack_wait[%0d]: got req=%b done=%b exp 1 000",
                         i, mem_req, core_done);
            end
            step();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h55AA55AA;
        step();
        checks++;
        if (core_done !== 3'b001 || core_err !== 3'b000 || core_rdata !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL tmo_ack8: got done=%b err=%b rdata=%h exp 001 000 55aa55aa",
                     core_done, core_err, core_rdata);
        end
        mem_ack = 1'b0;
        step();
        gnt_arb  = 3'b100;
        core_req = 3'b100;
        step();
        gnt_arb  = 3'b000;
        core_req = 3'b000;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_req !== 1'b1 || core_done !== 3'b000 || core_err !== 3'b000) begin
                errors++;
                $display("FAIL tmo_wait[%0d]: got req=%b done=%b err=%b exp 1 000 000",
                         i, mem_req, core_done, core_err);
            end
            step();
        end
        checks++;
        if (core_done !== 3'b100 || core_err !== 3'b100 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL tmo_done: got done=%b err=%b req=%b exp 100 100 0",
                     core_done, core_err, mem_req);
        end
        checks++;
        if (core_rdata !== 32'h0) begin
            errors++;
            $display("FAIL tmo_rdata: got %h exp 0", core_rdata);
        end
        step();
        checks++;
        if (core_err !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_after: got err=%b busy=%b exp 000 0", core_err, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_zero_wait_write();
        test_grant_while_busy();
        test_grant_no_req();
        test_reset_mid_bus();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
